reg_scoreboard: RTL and testbench

Register-file scoreboard and issue controller for the pipelined core. Sits in the decode stage, beside the destination-register select. It resolves the destination register of each decoded instruction using the same encoding as that select: 00 = rt, 01 = r31, 10 = rd. It records in-flight writes, clears them at writeback, and raises a stall for read-after-write (RAW) or write-after-write (WAW) conflicts. It also exposes stall statistics and a sticky error flag to the debug unit.

---
 rtl/reg_scoreboard_if.sv | 40 ++++
 rtl/reg_scoreboard.sv | 83 ++++++++
 tb/tb_reg_scoreboard.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Bundle of decode/writeback signals between the issue logic and the register scoreboard.
// The decode side offers id_valid. The scoreboard accepts the instruction with id_issue,
// which equals id_valid && !stall. An instruction is consumed only on a cycle where
// id_valid and id_issue are both high; otherwise decode holds it unchanged.
interface reg_scoreboard_if #(
  parameter int NBITS   = 5,
  parameter int NREGS   = 32,
  parameter int SELBITS = 2,
  parameter int CNTBITS = 32
);
  logic               id_valid;
  logic [NBITS-1:0]   id_rs;
  logic [NBITS-1:0]   id_rt;
  logic [NBITS-1:0]   id_rd;
  logic               id_use_rs;
  logic               id_use_rt;
  logic               id_reg_write;
  logic [SELBITS-1:0] id_sel_reg;
  logic               wb_valid;
  logic [NBITS-1:0]   wb_reg;
  logic               flush_all;
  logic               stall;
  logic [NBITS-1:0]   id_dst;
  logic               id_issue;
  logic [NREGS-1:0]   pending;
  logic [CNTBITS-1:0] stall_cnt;
  logic               err;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_reg_write,
           id_sel_reg, wb_valid, wb_reg, flush_all,
    input  stall, id_dst, id_issue, pending, stall_cnt, err
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_reg_write,
           id_sel_reg, wb_valid, wb_reg, flush_all,
    output stall, id_dst, id_issue, pending, stall_cnt, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: tracks in-flight writes, stalls decode on RAW/WAW hazards,
// and keeps a saturating stall counter plus a sticky bad-writeback error flag.
module reg_scoreboard #(
  parameter int NBITS   = 5,
  parameter int NREGS   = 32,
  parameter int SELBITS = 2,
  parameter int CNTBITS = 32
) (
  input logic             clk,
  input logic             rst_n,
  reg_scoreboard_if.slave sb
);

  logic [NREGS-1:0]   pending_q;
  logic [NREGS-1:0]   pending_nxt;
  logic [NREGS-1:0]   eff;
  logic [CNTBITS-1:0] stall_cnt_q;
  logic               err_q;
  logic [NBITS-1:0]   dst;
  logic               dst_we;
  logic               stall;
  logic               issue;

  // Destination select uses the same encoding as the datapath mux.
  always_comb begin
    dst = '0;
    case (sb.id_sel_reg)
      SELBITS'(0): dst = sb.id_rt;
      SELBITS'(1): dst = '1;
      SELBITS'(2): dst = sb.id_rd;
      default:     dst = '0;
    endcase
  end

  assign dst_we = sb.id_reg_write && (sb.id_sel_reg != '1) && (dst != '0);

  // The register file writes in the first half-cycle, so a retiring write unblocks readers now.
  always_comb begin
    eff = pending_q;
    for (int i = 0; i < NREGS; i++) begin
      if (sb.wb_valid && (sb.wb_reg == NBITS'(i))) eff[i] = 1'b0;
    end
    eff[0] = 1'b0;
  end

  assign stall = sb.id_valid && ((sb.id_use_rs && eff[sb.id_rs]) ||
                                 (sb.id_use_rt && eff[sb.id_rt]) ||
                                 (dst_we && eff[dst]));
  assign issue = sb.id_valid && !stall;

  // Set is applied after clear so a same-cycle retire and re-issue leaves the bit set.
  always_comb begin
    pending_nxt = pending_q;
    if (sb.flush_all) begin
      pending_nxt = '0;
    end else begin
      if (sb.wb_valid) pending_nxt[sb.wb_reg] = 1'b0;
      if (issue && dst_we) pending_nxt[dst] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      pending_q <= pending_nxt;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNTBITS'(1);
      if (sb.wb_valid && !pending_q[sb.wb_reg] && (sb.wb_reg != '0) && !sb.flush_all)
        err_q <= 1'b1;
    end
  end

  assign sb.stall     = stall;
  assign sb.id_issue  = issue;
  assign sb.id_dst    = dst;
  assign sb.pending   = pending_q;
  assign sb.stall_cnt = stall_cnt_q;
  assign sb.err       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazard stalls, writeback bypass, r31 link writes,
// r0/no-dest handling, sticky error, flush and asynchronous reset.
module tb_reg_scoreboard;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  reg_scoreboard_if #(.NBITS(5), .NREGS(32), .SELBITS(2), .CNTBITS(32)) sb ();

  reg_scoreboard #(.NBITS(5), .NREGS(32), .SELBITS(2), .CNTBITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%08h exp=0x%08h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_pending(input logic [31:0] exp);
    exp_q.push_back(exp);
    check("pending", sb.pending, exp_q.pop_front());
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sb.id_valid = 0; sb.id_rs = 0; sb.id_rt = 0; sb.id_rd = 0;
    sb.id_use_rs = 0; sb.id_use_rt = 0; sb.id_reg_write = 0; sb.id_sel_reg = 2'b11;
    sb.wb_valid = 0; sb.wb_reg = 0; sb.flush_all = 0;
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic use_rs, input logic use_rt, input logic rw,
                          input logic [1:0] sel);
    sb.id_valid = 1; sb.id_rs = rs; sb.id_rt = rt; sb.id_rd = rd;
    sb.id_use_rs = use_rs; sb.id_use_rt = use_rt; sb.id_reg_write = rw; sb.id_sel_reg = sel;
  endtask

  task automatic drive_wb(input logic [4:0] r);
    sb.wb_valid = 1; sb.wb_reg = r;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rst_n = 0;
    #23;
    check("rst_pending", sb.pending, 32'h0);
    check("rst_cnt", sb.stall_cnt, 32'd0);
    check("rst_err", {31'd0, sb.err}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // Issue write to r8, then a RAW reader of r8 stalls for two cycles.
    drive_id(5'd0, 5'd0, 5'd8, 0, 0, 1, 2'b10);
    #1;
    check("dst_rd8", {27'd0, sb.id_dst}, 32'd8);
    check("issue_rd8", {31'd0, sb.id_issue}, 32'd1);
    tick();
    check_pending(32'h0000_0100);
    clear_inputs();
    drive_id(5'd8, 5'd0, 5'd0, 1, 0, 0, 2'b11);
    #1;
    check("raw_stall", {31'd0, sb.stall}, 32'd1);
    check("raw_noissue", {31'd0, sb.id_issue}, 32'd0);
    tick();
    check("cnt_1", sb.stall_cnt, 32'd1);
    tick();
    check("cnt_2", sb.stall_cnt, 32'd2);
    drive_wb(5'd8);
    #1;
    check("raw_release", {31'd0, sb.stall}, 32'd0);
    check("raw_issue", {31'd0, sb.id_issue}, 32'd1);
    tick();
    check_pending(32'h0);
    check("cnt_hold", sb.stall_cnt, 32'd2);
    check("err_clean", {31'd0, sb.err}, 32'd0);

    // JAL link write to r31, then WAW on r31 held until writeback.
    clear_inputs();
    drive_id(5'd0, 5'd4, 5'd9, 0, 0, 1, 2'b01);
    #1;
    check("dst_jal", {27'd0, sb.id_dst}, 32'd31);
    tick();
    check_pending(32'h8000_0000);
    clear_inputs();
    drive_id(5'd0, 5'd0, 5'd31, 0, 0, 1, 2'b10);
    #1;
    check("waw_stall", {31'd0, sb.stall}, 32'd1);
    tick();
    check("cnt_3", sb.stall_cnt, 32'd3);
    drive_wb(5'd31);
    #1;
    check("waw_release", {31'd0, sb.stall}, 32'd0);
    tick();
    check_pending(32'h8000_0000);
    clear_inputs();
    drive_wb(5'd31);
    tick();
    check_pending(32'h0);

    // Same-cycle retire of r5 and re-issue to rt=5: no stall, bit stays set.
    clear_inputs();
    drive_id(5'd0, 5'd5, 5'd0, 0, 0, 1, 2'b00);
    tick();
    check_pending(32'h0000_0020);
    drive_wb(5'd5);
    #1;
    check("r5_nostall", {31'd0, sb.stall}, 32'd0);
    tick();
    check_pending(32'h0000_0020);
    clear_inputs();
    drive_wb(5'd5);
    tick();
    check_pending(32'h0);
    check("err_still0", {31'd0, sb.err}, 32'd0);

    // r0 and no-destination writes never mark pending.
    clear_inputs();
    drive_id(5'd0, 5'd0, 5'd0, 1, 1, 1, 2'b10);
    #1;
    check("r0_nostall", {31'd0, sb.stall}, 32'd0);
    tick();
    check_pending(32'h0);
    drive_id(5'd0, 5'd7, 5'd7, 0, 0, 1, 2'b11);
    #1;
    check("sel11_dst", {27'd0, sb.id_dst}, 32'd0);
    tick();
    check_pending(32'h0);

    // Writeback to non-pending r3 sets a sticky error.
    clear_inputs();
    drive_wb(5'd3);
    tick();
    check("err_set", {31'd0, sb.err}, 32'd1);
    clear_inputs();
    tick();
    tick();
    check("err_sticky", {31'd0, sb.err}, 32'd1);

    // Build pending = 0xF00, stall once, then flush (issue ignored, counter kept).
    for (int r = 8; r < 12; r++) begin
      clear_inputs();
      drive_id(5'd0, 5'd0, 5'(r), 0, 0, 1, 2'b10);
      tick();
    end
    check_pending(32'h0000_0F00);
    clear_inputs();
    drive_id(5'd0, 5'd10, 5'd0, 0, 1, 0, 2'b11);
    tick();
    check("cnt_4", sb.stall_cnt, 32'd4);
    clear_inputs();
    drive_id(5'd0, 5'd0, 5'd12, 0, 0, 1, 2'b10);
    sb.flush_all = 1;
    tick();
    check_pending(32'h0);
    check("flush_cnt", sb.stall_cnt, 32'd4);

    // Reset asserted in the middle of a stall.
    clear_inputs();
    drive_id(5'd0, 5'd0, 5'd20, 0, 0, 1, 2'b10);
    tick();
    clear_inputs();
    drive_id(5'd20, 5'd0, 5'd0, 1, 0, 0, 2'b11);
    tick();
    check("cnt_5", sb.stall_cnt, 32'd5);
    #1;
    check("pre_rst_stall", {31'd0, sb.stall}, 32'd1);
    rst_n = 0;
    #1;
    check("arst_pending", sb.pending, 32'h0);
    check("arst_cnt", sb.stall_cnt, 32'd0);
    check("arst_err", {31'd0, sb.err}, 32'd0);
    check("arst_stall", {31'd0, sb.stall}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("post_rst_issue", {31'd0, sb.id_issue}, 32'd1);
    tick();
    check_pending(32'h0);

    // Idle decode never stalls or issues.
    clear_inputs();
    sb.id_use_rs = 1;
    sb.id_rs = 5'd20;
    #1;
    check("idle_stall", {31'd0, sb.stall}, 32'd0);
    check("idle_issue", {31'd0, sb.id_issue}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
